// File: rtl/aes_dec_pkg.sv
// Shared AES decryption definitions: block size, state type, iterative-FSM encodings.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package aes_dec_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    // Byte 0 of the AES state sits in the most significant byte.
    typedef logic [8*AES_BLOCK_BYTES-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    // Group counter width: enough to count 16/n groups, never narrower than 1 bit.
    function automatic int grp_cnt_width(input int n);
        return (AES_BLOCK_BYTES / n > 1) ? $clog2(AES_BLOCK_BYTES / n) : 1;
    endfunction

    function automatic bit bpc_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: one byte in, one byte out, pure 256-entry lookup.
// Latency: combinational.
// Backpressure: none.
// Ports: byte_i - byte to substitute; byte_o - InvSBOX(byte_i).
module inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [7:0] INV_TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign byte_o = INV_TBL[byte_i];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per cycle.
// Latency: 16/BYTES_PER_CYCLE cycles from acceptance edge to out_valid; one block in flight.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE; abort flushes to IDLE.
// Ports: clk/rst (async active-high), abort (sync flush), in_valid/in_ready/in_data (input block),
//        out_valid/out_ready/out_data (result, byte 0 = MSB), busy (RUN or DONE).
module inv_sub_bytes_iter
    import aes_dec_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int N      = BYTES_PER_CYCLE;
    localparam int GROUPS = AES_BLOCK_BYTES / N;
    localparam int CW     = grp_cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(GROUPS - 1);

    if (!bpc_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
        $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    fsm_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    aes_state_t  blk_q, blk_d;

    // Byte view of the held block, byte 0 first.
    logic [7:0] cur_bytes [AES_BLOCK_BYTES];
    logic [3:0] grp_base;
    logic [7:0] sb_in  [N];
    logic [7:0] sb_out [N];
    aes_state_t sub_state;

    always_comb begin
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            cur_bytes[i] = blk_q[8*(AES_BLOCK_BYTES-1-i) +: 8];
        end
    end

    // First byte of the group handled this cycle; counter never exceeds GROUPS-1,
    // so this stays within 0..16-N.
    assign grp_base = 4'(int'(cnt_q) * N);

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign sb_in[k] = cur_bytes[grp_base + 4'(k)];
        inv_sbox u_inv_sbox (
            .byte_i (sb_in[k]),
            .byte_o (sb_out[k])
        );
    end

    // Block with the current group replaced, all other bytes untouched.
    always_comb begin
        sub_state = blk_q;
        for (int k = 0; k < N; k++) begin
            sub_state[8*(AES_BLOCK_BYTES-1-(int'(grp_base)+k)) +: 8] = sb_out[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        if (abort) begin
            // Flush wins over any handshake; the block register is left as-is.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        blk_d   = in_data;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    blk_d = sub_state;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_data  = blk_q;
    end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: three instances (N=4, 1, 16) share one stimulus stream.
// Expected results come from a mathematically derived S-box (GF(2^8) inverse + affine map).
// A negedge monitor per instance compares outputs against a shared expected-value queue.
module tb_inv_sub_bytes_iter;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;

    logic         in_ready_w  [NI];
    logic         out_valid_w [NI];
    logic         busy_w      [NI];
    logic [127:0] out_data_w  [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        inv_sub_bytes_iter #(.BYTES_PER_CYCLE(NG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .abort     (abort),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .in_data   (in_data),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .out_data  (out_data_w[g]),
            .busy      (busy_w[g])
        );
    end

    int lat_tab [NI] = '{4, 16, 1};

    int total = 0;
    int passed = 0;
    int cyc = 0;
    logic [127:0] exp_q [$];
    int rd [NI] = '{0, 0, 0};
    int acc_cyc [NI] = '{0, 0, 0};
    bit prev_vld [NI] = '{0, 0, 0};

    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return 8'((v << k) | (v >> (8 - k)));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xi = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            end
            s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
            sbox_t[x] = s;
            inv_t[s]  = 8'(x);
        end
    endtask

    function automatic logic [127:0] inv_sub(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_t[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input bit ok, input string name, input int inst,
                       input logic [127:0] act, input logic [127:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s inst=%0d actual=%h required=%h", name, inst, act, req);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                prev_vld[i] = 1'b0;
            end else begin
                if (out_valid_w[i]) begin
                    if (!prev_vld[i])
                        chk((cyc - acc_cyc[i]) == lat_tab[i], "latency", i,
                            128'(cyc - acc_cyc[i]), 128'(lat_tab[i]));
                    chk(in_ready_w[i] == 1'b0, "in_ready_in_done", i, 128'(in_ready_w[i]), 128'(0));
                    if (rd[i] < exp_q.size()) begin
                        chk(out_data_w[i] == exp_q[rd[i]], "out_data", i, out_data_w[i], exp_q[rd[i]]);
                        if (out_ready && !abort) rd[i]++;
                    end else begin
                        chk(1'b0, "unexpected_out_valid", i, 128'(out_valid_w[i]), 128'(0));
                    end
                end
                if (in_valid && in_ready_w[i] && !abort) acc_cyc[i] = cyc + 1;
                prev_vld[i] = out_valid_w[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit all_done();
        for (int i = 0; i < NI; i++) if (rd[i] != exp_q.size()) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_vld();
        for (int i = 0; i < NI; i++) if (!out_valid_w[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        for (int i = 0; i < NI; i++) rd[i] = 0;
    endtask

    // Called just after a rising edge with every instance idle.
    task automatic send(input logic [127:0] d, input logic [127:0] e);
        exp_q.push_back(e);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand128();
        for (int i = 0; i < NI; i++)
            chk(busy_w[i] == 1'b1, "accept", i, 128'(busy_w[i]), 128'(1));
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (!all_done() && n < 200) begin
            @(posedge clk);
            #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        if (!all_done()) chk(1'b0, "drain_timeout", 0, 128'(n), 128'(200));
        out_ready = 1'b0;
        clear_sb();
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < NI; i++) begin
            chk(in_ready_w[i] == 1'b1, {name, "_in_ready"}, i, 128'(in_ready_w[i]), 128'(1));
            chk(out_valid_w[i] == 1'b0, {name, "_out_valid"}, i, 128'(out_valid_w[i]), 128'(0));
            chk(busy_w[i] == 1'b0, {name, "_busy"}, i, 128'(busy_w[i]), 128'(0));
            chk(out_data_w[i] == 128'(0), {name, "_out_data"}, i, out_data_w[i], 128'(0));
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog inst=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        int n;

        build_tables();
        #2;
        check_reset_outputs("reset_init");
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Known vector: forward S-box of 00..0f.
        send(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f);
        drain(1'b0);
        send('0, {16{8'h52}});
        drain(1'b0);
        send({16{8'h16}}, {16{8'hff}});
        drain(1'b1);

        // Random blocks with random downstream stalls.
        repeat (20) begin
            d = rand128();
            send(d, inv_sub(d));
            drain(1'b1);
        end

        // Backpressure: hold the result for 10 cycles while in_valid pulses.
        d = rand128();
        send(d, inv_sub(d));
        out_ready = 1'b0;
        n = 0;
        while (!all_vld() && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand128();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk(rd[i] == 1, "bp_consumed", i, 128'(rd[i]), 128'(1));
            chk(in_ready_w[i] == 1'b1, "bp_release_idle", i, 128'(in_ready_w[i]), 128'(1));
            chk(out_valid_w[i] == 1'b0, "bp_release_vld", i, 128'(out_valid_w[i]), 128'(0));
        end
        out_ready = 1'b0;
        clear_sb();
        d = rand128();
        send(d, inv_sub(d));
        drain(1'b1);

        // Abort in the second RUN cycle, together with in_valid.
        d = rand128();
        send(d, inv_sub(d));
        @(posedge clk);
        #1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand128();
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk(out_valid_w[i] == 1'b0, "abort_out_valid", i, 128'(out_valid_w[i]), 128'(0));
            chk(in_ready_w[i] == 1'b1, "abort_in_ready", i, 128'(in_ready_w[i]), 128'(1));
            chk(busy_w[i] == 1'b0, "abort_busy", i, 128'(busy_w[i]), 128'(0));
        end
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        d = rand128();
        send(d, inv_sub(d));
        drain(1'b1);

        // Asynchronous reset mid-RUN (DONE already for the 16-byte instance).
        d = rand128();
        send(d, inv_sub(d));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_run");
        clear_sb();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Asynchronous reset in DONE.
        d = rand128();
        send(d, inv_sub(d));
        repeat (18) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            chk(out_valid_w[i] == 1'b1, "done_before_rst", i, 128'(out_valid_w[i]), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_done");
        clear_sb();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Byte 0 sweep: InvSBOX(SBOX(x)) must return x for every x.
        for (int x = 0; x < 256; x++) begin
            d = rand128();
            d[127:120] = sbox_t[x];
            e = inv_sub(d);
            e[127:120] = 8'(x);
            send(d, e);
            drain(1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

Interface
REQ-001 SHALL have parameter BYTES_PER_CYCLE, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port abort, input, 1: synchronous flush.
REQ-005 SHALL have port in_valid, input, 1: in_data valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts in_data.
REQ-007 SHALL have port in_data, input, 128: AES state; byte 0 = in_data[127:120], byte 15 = in_data[7:0].
REQ-008 SHALL have port out_valid, output, 1: out_data valid.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts out_data.
REQ-010 SHALL have port out_data, output, 128: InvSubBytes(in_data), same byte order.
REQ-011 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE), out_valid = (state==DONE), out_data driven from internal 128-bit state register at all times.
REQ-013 IDLE: in_valid=1 at an edge -> load in_data into state register, byte counter cleared to 0, go RUN; in_valid=0 -> stay IDLE.
REQ-014 RUN: each cycle, bytes [cnt*N .. cnt*N+N-1] (N=BYTES_PER_CYCLE) of the state register SHALL be replaced by their AES inverse S-box values; other bytes unchanged; cnt increments.
REQ-015 RUN SHALL last exactly 16/N cycles; on the edge writing the final group, go DONE and clear cnt; latency from acceptance edge to out_valid high = 16/N cycles (4 for N=4).
REQ-016 DONE: out_valid held high and out_data stable until out_ready=1 at an edge, then go IDLE; in_ready stays low in DONE (no overlap, one block in flight).
REQ-017 Counter SHALL be log2(16/N) bits min 1, wrap-free: never exceeds 16/N-1.
REQ-018 abort=1 at an edge SHALL force IDLE, clear cnt, keep state register contents, from any state; abort has priority over in_valid and out_ready in the same cycle.
REQ-019 in_valid/in_data changes while not in IDLE SHALL be ignored; out_ready while not in DONE SHALL be ignored.
REQ-020 Inverse S-box mapping SHALL be the exact inverse of the team's forward SBOX table for all 256 inputs (e.g. 0x63->0x00, 0x00->0x52, 0x16->0xff).

Reset
REQ-021 rst=1 SHALL immediately force IDLE, cnt=0, state register=0; hence in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-022 Reset asserted mid-RUN or in DONE SHALL discard the block; no out_valid after release until a new acceptance.

Structure
REQ-023 Shared package aes_dec_pkg SHALL hold AES_BLOCK_BYTES=16, the 128-bit state typedef, and the FSM state enum/encodings.
REQ-024 SHALL instantiate N copies of sub-module inv_sbox (8-bit in, 8-bit out, purely combinational 256-entry table); datapath mux selects group cnt.
REQ-025 Block SHALL elaborate with an error for illegal BYTES_PER_CYCLE.

Verification
REQ-026 N=4, in_data = 63 7c 77 7b f2 6b 6f c5 30 01 67 2b fe d7 ab 76 -> out_data = 00 01 02 03 04 05 06 07 08 09 0a 0b 0c 0d 0e 0f, out_valid exactly 4 cycles after acceptance.
REQ-027 in_data all 0x00 -> all 0x52; all 0x16 -> all 0xff; repeat for N=1 (latency 16) and N=16 (latency 1).
REQ-028 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle, next block accepted following cycle.
REQ-029 abort asserted in 2nd RUN cycle together with in_valid -> IDLE next edge, no out_valid; subsequent block processed correctly.
REQ-030 rst pulsed asynchronously mid-RUN and in DONE -> outputs reach reset values without clock edge; exhaustive 256-value sweep via byte 0 checks inv_sbox(SBOX(x))=x.
